// File: rtl/lamp_event_controller.sv
// rtl/lamp_event_controller.sv - push-button/presence front end producing a/b/c/d command pulses
module lamp_event_controller #(
  parameter int DEBOUNCE_CYC    = 100,
  parameter int LONG_PRESS_CYC  = 300,
  parameter int OFF_TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic infrared,
  input  logic lamp_on_auto,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYC) + 1;
  localparam int TMO_W  = $clog2(OFF_TIMEOUT_CYC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(OFF_TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG, WAIT_REL} press_state_t;

  // bit 0 = push-button, bit 1 = infrared
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];
  logic            btn_db;
  logic            ir_db;
  logic            ir_db_q;

  press_state_t    state;
  press_state_t    state_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic [HOLD_W-1:0] hold_inc;
  logic            a_next;
  logic            b_next;

  logic [TMO_W-1:0] tmo;
  logic             tmo_run;

  assign raw    = {infrared, push};
  assign btn_db = db[0];
  assign ir_db  = db[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // a is issued on the same edge at which the hold count reaches its last value
  always_comb begin
    state_next = state;
    hold_next  = hold;
    a_next     = 1'b0;
    b_next     = 1'b0;
    hold_inc   = (hold == '1) ? hold : hold + 1'b1;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_next = HELD;
          hold_next  = '0;
        end
      end
      HELD: begin
        if (!btn_db) begin
          b_next     = 1'b1;
          state_next = IDLE;
        end else begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            a_next     = 1'b1;
            state_next = LONG;
          end
        end
      end
      LONG:     state_next = btn_db ? WAIT_REL : IDLE;
      WAIT_REL: if (!btn_db) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      a     <= 1'b0;
      b     <= 1'b0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      a     <= a_next;
      b     <= b_next;
    end
  end

  // presence clears the timeout, so c can never coincide with d
  assign tmo_run = lamp_on_auto & ~ir_db;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo     <= '0;
      c       <= 1'b0;
      d       <= 1'b0;
      ir_db_q <= 1'b0;
    end else begin
      ir_db_q <= ir_db;
      d       <= ir_db & ~ir_db_q;
      c       <= 1'b0;
      if (!tmo_run) begin
        tmo <= '0;
      end else if (tmo == TMO_LAST) begin
        tmo <= '0;
        c   <= 1'b1;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lamp_event_controller.sv
// tb/tb_lamp_event_controller.sv - directed checks of press, bounce, timeout, presence and reset behaviour
module tb_lamp_event_controller;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int OFF  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic infrared = 1'b0;
  logic lamp_on_auto = 1'b0;
  logic a, b, c, d;

  int checks = 0;
  int errors = 0;
  int na, nb, nc, nd;
  int first_a, first_b, first_c, first_d, last_c;
  int ab_both, cd_both;

  always #5 clk = ~clk;

  lamp_event_controller #(
    .DEBOUNCE_CYC   (DEB),
    .LONG_PRESS_CYC (LONG),
    .OFF_TIMEOUT_CYC(OFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .infrared    (infrared),
    .lamp_on_auto(lamp_on_auto),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    push         = 1'b0;
    infrared     = 1'b0;
    lamp_on_auto = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({a, b, c, d}), 0);
    rst = 1'b0;
  endtask

  // cycle k: inputs driven just after edge k, outputs sampled at the following negedge
  task automatic run(input int tid, input int n);
    na = 0; nb = 0; nc = 0; nd = 0;
    first_a = -1; first_b = -1; first_c = -1; first_d = -1; last_c = -1;
    ab_both = 0; cd_both = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      case (tid)
        1: push = (k <= 9);
        2: push = (k <= 59);
        3: push = (k < 25) && ((k % 5) < 3);
        4: begin lamp_on_auto = 1'b1; infrared = 1'b0; end
        5: begin lamp_on_auto = 1'b1; infrared = (k <= 99); end
        6: begin push = 1'b1; rst = (k == 15); end
        7: begin lamp_on_auto = 1'b1; infrared = (k >= 20 && k <= 29); end
        default: ;
      endcase
      @(negedge clk);
      if (a) begin if (na == 0) first_a = k; na++; end
      if (b) begin if (nb == 0) first_b = k; nb++; end
      if (c) begin if (nc == 0) first_c = k; last_c = k; nc++; end
      if (d) begin if (nd == 0) first_d = k; nd++; end
      if (a && b) ab_both++;
      if (c && d) cd_both++;
    end
  endtask

  initial begin
    do_reset();
    run(1, 40);
    check("short_b_count", nb, 1);
    check("short_b_cycle", first_b, 17);
    check("short_a_count", na, 0);
    check("short_c_count", nc, 0);

    do_reset();
    run(2, 90);
    check("long_a_count", na, 1);
    check("long_a_cycle", first_a, 26);
    check("long_b_count", nb, 0);
    check("long_ab_overlap", ab_both, 0);

    do_reset();
    run(3, 40);
    check("bounce_a_count", na, 0);
    check("bounce_b_count", nb, 0);

    do_reset();
    run(4, 101);
    check("tmo_c_count", nc, 2);
    check("tmo_c_first", first_c, 50);
    check("tmo_c_rearm", last_c, 100);
    check("tmo_d_count", nd, 0);

    do_reset();
    run(7, 101);
    check("tmo_ir_d_cycle", first_d, 27);
    check("tmo_ir_c_count", nc, 1);
    check("tmo_ir_c_cycle", first_c, 86);
    check("tmo_ir_cd_overlap", cd_both, 0);

    do_reset();
    run(5, 100);
    check("pres_d_count", nd, 1);
    check("pres_d_cycle", first_d, 7);
    check("pres_c_count", nc, 0);

    do_reset();
    run(6, 70);
    check("rst_a_count", na, 1);
    check("rst_a_cycle", first_a, 16 + LONG + DEB + 2);
    check("rst_b_count", nb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
